// File: rtl/stream_framer.sv
// Trigger-debounced pixel capture into a FIFO, emitted as TLAST-framed AXI-Stream
// frames of 2**FRAME_LEN_LOG2 beats with full backpressure, all in pixel_clk.
module stream_framer #(
   parameter int C_M00_AXIS_TDATA_WIDTH = 32,
   parameter int PIXEL_WIDTH            = 24,
   parameter int FRAME_LEN_LOG2         = 16,
   parameter int FRAMES_PER_TRIGGER     = 1,
   parameter int DEBOUNCE_CYCLES        = 255,
   parameter int FIFO_DEPTH_LOG2        = 4
) (
   input  logic                                  pixel_clk,
   input  logic                                  pixel_rst,
   input  logic [PIXEL_WIDTH-1:0]                pixel_data,
   input  logic                                  pixel_valid,
   input  logic                                  trigger,
   input  logic                                  m00_axis_tready,
   output logic                                  m00_axis_tvalid,
   output logic                                  m00_axis_tlast,
   output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
   output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
   output logic                                  busy,
   output logic                                  overflow,
   output logic [15:0]                           drop_count,
   output logic [15:0]                           frames_sent
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   localparam int          FIFO_DEPTH = 2 ** FIFO_DEPTH_LOG2;
   localparam logic [FIFO_DEPTH_LOG2:0] FIFO_FULL_CNT = (FIFO_DEPTH_LOG2+1)'(FIFO_DEPTH);
   localparam logic [15:0] DEB_HIT    = 16'(DEBOUNCE_CYCLES - 1);
   localparam logic [15:0] FPT        = 16'(FRAMES_PER_TRIGGER);

   state_t state_q, state_d;

   logic                         trig_meta_q, trig_sync_q;
   logic [15:0]                  deb_cnt_q, deb_cnt_d;
   logic                         start;

   logic                         in_valid_q, in_valid_d;
   logic [PIXEL_WIDTH-1:0]       in_data_q;
   logic [FRAME_LEN_LOG2-1:0]    in_cnt_q, in_cnt_d;
   logic [15:0]                  frame_cnt_q, frame_cnt_d;

   logic [PIXEL_WIDTH:0]         mem_q [FIFO_DEPTH];
   logic [FIFO_DEPTH_LOG2:0]     wr_ptr_q, rd_ptr_q, fifo_count;
   logic                         fifo_full, fifo_empty, wr_en, rd_en, drop, wr_last;

   logic                         out_valid_q, out_last_q;
   logic [PIXEL_WIDTH-1:0]       out_data_q;
   logic                         handshake;

   logic                         overflow_q;
   logic [15:0]                  drop_cnt_q, frames_sent_q;

   // Two-flop synchroniser followed by a saturating high-time counter; start fires
   // on the single cycle the counter steps onto DEBOUNCE_CYCLES.
   always_ff @(posedge pixel_clk or posedge pixel_rst) begin
      if (pixel_rst) begin
         trig_meta_q <= 1'b0;
         trig_sync_q <= 1'b0;
         deb_cnt_q   <= '0;
      end else begin
         trig_meta_q <= trigger;
         trig_sync_q <= trig_meta_q;
         deb_cnt_q   <= deb_cnt_d;
      end
   end

   always_comb begin
      deb_cnt_d = deb_cnt_q;
      if (!trig_sync_q)
         deb_cnt_d = '0;
      else if (deb_cnt_q != 16'hFFFF)
         deb_cnt_d = deb_cnt_q + 16'd1;
   end

   assign start = trig_sync_q && (deb_cnt_q == DEB_HIT);

   // Full is judged on the registered pointers, so a same-cycle read never frees room.
   assign fifo_count = wr_ptr_q - rd_ptr_q;
   assign fifo_full  = (fifo_count == FIFO_FULL_CNT);
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign wr_en      = in_valid_q && !fifo_full;
   assign drop       = in_valid_q && fifo_full;
   assign wr_last    = (in_cnt_q == '1);
   assign handshake  = out_valid_q && m00_axis_tready;
   assign rd_en      = !fifo_empty && (!out_valid_q || m00_axis_tready);

   always_comb begin
      state_d     = state_q;
      frame_cnt_d = frame_cnt_q;
      in_cnt_d    = in_cnt_q;
      in_valid_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d     = RUN;
               frame_cnt_d = '0;
            end
         end
         RUN: begin
            if (wr_en) begin
               in_cnt_d = in_cnt_q + 1'b1;
               if (wr_last) begin
                  frame_cnt_d = frame_cnt_q + 16'd1;
                  if (FRAMES_PER_TRIGGER == 0) begin
                     if (!trig_sync_q)
                        state_d = DRAIN;
                  end else if (frame_cnt_q + 16'd1 == FPT) begin
                     state_d = DRAIN;
                  end
               end
            end
         end
         DRAIN: begin
            if (fifo_empty && !out_valid_q)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Nothing is captured on the cycle the frame closes, so no sample leaks into DRAIN.
      if (state_q == RUN && state_d == RUN)
         in_valid_d = pixel_valid;
   end

   always_ff @(posedge pixel_clk or posedge pixel_rst) begin
      if (pixel_rst) begin
         state_q     <= IDLE;
         frame_cnt_q <= '0;
         in_cnt_q    <= '0;
         in_valid_q  <= 1'b0;
         in_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         frame_cnt_q <= frame_cnt_d;
         in_cnt_q    <= in_cnt_d;
         in_valid_q  <= in_valid_d;
         in_data_q   <= pixel_data;
      end
   end

   always_ff @(posedge pixel_clk) begin
      if (wr_en)
         mem_q[wr_ptr_q[FIFO_DEPTH_LOG2-1:0]] <= {wr_last, in_data_q};
   end

   // FIFO pointers and the registered output beat, which refills on the handshake edge.
   always_ff @(posedge pixel_clk or posedge pixel_rst) begin
      if (pixel_rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
      end else begin
         if (wr_en)
            wr_ptr_q <= wr_ptr_q + 1'b1;
         if (rd_en) begin
            rd_ptr_q    <= rd_ptr_q + 1'b1;
            out_valid_q <= 1'b1;
            {out_last_q, out_data_q} <= mem_q[rd_ptr_q[FIFO_DEPTH_LOG2-1:0]];
         end else if (handshake) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge pixel_clk or posedge pixel_rst) begin
      if (pixel_rst) begin
         overflow_q    <= 1'b0;
         drop_cnt_q    <= '0;
         frames_sent_q <= '0;
      end else begin
         if (drop) begin
            overflow_q <= 1'b1;
            if (drop_cnt_q != 16'hFFFF)
               drop_cnt_q <= drop_cnt_q + 16'd1;
         end
         if (handshake && out_last_q)
            frames_sent_q <= frames_sent_q + 16'd1;
      end
   end

   assign m00_axis_tvalid = out_valid_q;
   assign m00_axis_tlast  = out_last_q;
   assign m00_axis_tdata  = C_M00_AXIS_TDATA_WIDTH'(out_data_q);
   assign m00_axis_tstrb  = '1;
   assign busy            = (state_q != IDLE);
   assign overflow        = overflow_q;
   assign drop_count      = drop_cnt_q;
   assign frames_sent     = frames_sent_q;

endmodule

// File: tb/tb_stream_framer.sv
// Scoreboard bench: a two-frame-per-trigger framer checked beat by beat, plus a
// continuous-mode instance checked for frame count and tlast placement.
module tb_stream_framer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [23:0] pixData = '0;
   logic        pixValid = 1'b0;
   logic        trig = 1'b0;
   logic        tready = 1'b1;
   logic        tvalid, tlast, busy, overflow;
   logic [31:0] tdata;
   logic [3:0]  tstrb;
   logic [15:0] dropCount, framesSent;

   logic        pixValidC = 1'b0;
   logic        trigC = 1'b0;
   logic        treadyC = 1'b1;
   logic        tvalidC, tlastC, busyC, overflowC;
   logic [31:0] tdataC;
   logic [3:0]  tstrbC;
   logic [15:0] dropCountC, framesSentC;

   int          checks = 0;
   int          failures = 0;
   int          readyMode = 0;
   int          beatCount = 0;
   int          beatsC = 0;
   int          lastsC = 0;
   int          expIdx = 0;
   logic [32:0] expQ [$];

   always #5 clk = ~clk;

   stream_framer #(
      .C_M00_AXIS_TDATA_WIDTH(32), .PIXEL_WIDTH(24), .FRAME_LEN_LOG2(4),
      .FRAMES_PER_TRIGGER(2), .DEBOUNCE_CYCLES(255), .FIFO_DEPTH_LOG2(4)
   ) dut (
      .pixel_clk(clk), .pixel_rst(rst), .pixel_data(pixData), .pixel_valid(pixValid),
      .trigger(trig), .m00_axis_tready(tready), .m00_axis_tvalid(tvalid),
      .m00_axis_tlast(tlast), .m00_axis_tdata(tdata), .m00_axis_tstrb(tstrb),
      .busy(busy), .overflow(overflow), .drop_count(dropCount), .frames_sent(framesSent)
   );

   stream_framer #(
      .C_M00_AXIS_TDATA_WIDTH(32), .PIXEL_WIDTH(24), .FRAME_LEN_LOG2(4),
      .FRAMES_PER_TRIGGER(0), .DEBOUNCE_CYCLES(255), .FIFO_DEPTH_LOG2(4)
   ) dutC (
      .pixel_clk(clk), .pixel_rst(rst), .pixel_data(pixData), .pixel_valid(pixValidC),
      .trigger(trigC), .m00_axis_tready(treadyC), .m00_axis_tvalid(tvalidC),
      .m00_axis_tlast(tlastC), .m00_axis_tdata(tdataC), .m00_axis_tstrb(tstrbC),
      .busy(busyC), .overflow(overflowC), .drop_count(dropCountC), .frames_sent(framesSentC)
   );

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pushExp(input int data);
      logic [31:0] word;
      word = 32'(data) & 32'h00FF_FFFF;
      expQ.push_back({((expIdx % 16) == 15), word});
      expIdx++;
   endtask

   // Drives n consecutive samples (with gap idle cycles between them); only the
   // first nPush are expected to survive to the output.
   task automatic applyStimulus(input int n, input int base, input int gap, input int nPush);
      for (int i = 0; i < n; i++) begin
         pixValid = 1'b1;
         pixData  = 24'(base + i);
         if (i < nPush)
            pushExp(base + i);
         tick();
         if (gap > 0) begin
            pixValid = 1'b0;
            repeat (gap) tick();
         end
      end
      pixValid = 1'b0;
   endtask

   task automatic waitBusy(input logic level, input int limit, input string name);
      int c = 0;
      while (busy !== level && c < limit) begin
         tick();
         c++;
      end
      checkOutput(name, 64'(busy), 64'(level));
   endtask

   task automatic waitDrained(input int limit, input string name);
      int c = 0;
      while ((expQ.size() != 0 || tvalid) && c < limit) begin
         tick();
         c++;
      end
      checkOutput(name, 64'(expQ.size()), 64'd0);
   endtask

   task automatic resetDut();
      rst      = 1'b1;
      trig     = 1'b0;
      trigC    = 1'b0;
      pixValid = 1'b0;
      repeat (3) tick();
      expQ.delete();
      expIdx = 0;
      rst    = 1'b0;
      tick();
   endtask

   always begin
      @(posedge clk);
      #1;
      case (readyMode)
         1:       tready = ~tready;
         2:       tready = 1'b0;
         default: tready = 1'b1;
      endcase
   end

   // Scoreboard monitor: pops one expectation per handshake, and checks that a
   // stalled beat stays put until it is taken.
   initial begin
      logic        heldValid;
      logic [33:0] heldWord;
      logic [32:0] expWord;
      heldValid = 1'b0;
      heldWord  = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            heldValid = 1'b0;
         end else begin
            if (heldValid)
               checkOutput("hold_stable", 64'({tvalid, tlast, tdata}), 64'(heldWord));
            heldValid = tvalid && !tready;
            heldWord  = {tvalid, tlast, tdata};
            if (tvalid && tready) begin
               beatCount++;
               if (expQ.size() == 0) begin
                  checks++;
                  failures++;
                  $display("[TB] FAIL unexpected_beat actual=%0h expected=none", {tlast, tdata});
               end else begin
                  expWord = expQ.pop_front();
                  checkOutput("beat", 64'({tlast, tdata}), 64'(expWord));
               end
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (!rst && tvalidC && treadyC) begin
            checkOutput("cont_tlast", 64'(tlastC), 64'((beatsC % 16) == 15));
            beatsC++;
            if (tlastC)
               lastsC++;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int startBeats;
      logic busySeen;

      // Reset state
      #1;
      checkOutput("rst_tvalid", 64'(tvalid), 64'd0);
      checkOutput("rst_tlast", 64'(tlast), 64'd0);
      checkOutput("rst_tdata", 64'(tdata), 64'd0);
      checkOutput("rst_tstrb", 64'(tstrb), 64'hF);
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_overflow", 64'(overflow), 64'd0);
      checkOutput("rst_drop", 64'(dropCount), 64'd0);
      checkOutput("rst_frames", 64'(framesSent), 64'd0);
      resetDut();

      // Two full frames at full rate with the trigger held long
      readyMode  = 0;
      startBeats = beatCount;
      trig = 1'b1;
      waitBusy(1'b1, 400, "t1_start");
      applyStimulus(32, 24'hA00000, 0, 32);
      waitBusy(1'b0, 200, "t1_idle");
      repeat (20) tick();
      trig = 1'b0;
      checkOutput("t1_busy_after_hold", 64'(busy), 64'd0);
      checkOutput("t1_beats", 64'(beatCount - startBeats), 64'd32);
      checkOutput("t1_frames", 64'(framesSent), 64'd2);
      checkOutput("t1_drop", 64'(dropCount), 64'd0);
      checkOutput("t1_overflow", 64'(overflow), 64'd0);

      // Short trigger glitches never start a frame
      resetDut();
      startBeats = beatCount;
      busySeen   = 1'b0;
      for (int g = 0; g < 5; g++) begin
         trig = 1'b1;
         for (int k = 0; k < 10; k++) begin tick(); busySeen |= busy; end
         trig = 1'b0;
         for (int k = 0; k < 10; k++) begin tick(); busySeen |= busy; end
      end
      for (int k = 0; k < 300; k++) begin tick(); busySeen |= busy; end
      checkOutput("t2_busy_seen", 64'(busySeen), 64'd0);
      checkOutput("t2_beats", 64'(beatCount - startBeats), 64'd0);

      // Toggling tready with half-rate samples
      resetDut();
      readyMode = 1;
      trig = 1'b1;
      waitBusy(1'b1, 400, "t3_start");
      trig = 1'b0;
      applyStimulus(32, 0, 1, 32);
      waitBusy(1'b0, 300, "t3_idle");
      waitDrained(50, "t3_queue");
      checkOutput("t3_drop", 64'(dropCount), 64'd0);
      checkOutput("t3_frames", 64'(framesSent), 64'd2);

      // Stalled output: 16 FIFO entries + 1 output beat kept, 23 of 40 dropped
      resetDut();
      readyMode = 2;
      repeat (2) tick();
      trig = 1'b1;
      waitBusy(1'b1, 400, "t4_start");
      trig = 1'b0;
      applyStimulus(40, 100, 0, 17);
      repeat (5) tick();
      checkOutput("t4_drop", 64'(dropCount), 64'd23);
      checkOutput("t4_overflow", 64'(overflow), 64'd1);
      checkOutput("t4_tvalid_held", 64'(tvalid), 64'd1);
      checkOutput("t4_busy", 64'(busy), 64'd1);
      readyMode = 0;
      waitDrained(100, "t4_queue");
      checkOutput("t4_frames_mid", 64'(framesSent), 64'd1);
      applyStimulus(15, 200, 0, 15);
      waitBusy(1'b0, 200, "t4_idle");
      waitDrained(50, "t4_queue_end");
      checkOutput("t4_frames", 64'(framesSent), 64'd2);
      checkOutput("t4_drop_end", 64'(dropCount), 64'd23);

      // Continuous mode: trigger released during frame 3
      resetDut();
      trigC = 1'b1;
      pixValidC = 1'b1;
      begin
         int c = 0;
         while (!busyC && c < 400) begin tick(); c++; end
         checkOutput("t5_start", 64'(busyC), 64'd1);
         repeat (40) tick();
         trigC = 1'b0;
         c = 0;
         while (busyC && c < 300) begin tick(); c++; end
         checkOutput("t5_idle", 64'(busyC), 64'd0);
      end
      pixValidC = 1'b0;
      checkOutput("t5_frames", 64'(framesSentC), 64'd3);
      checkOutput("t5_beats", 64'(beatsC), 64'd48);
      checkOutput("t5_lasts", 64'(lastsC), 64'd3);
      checkOutput("t5_drop", 64'(dropCountC), 64'd0);

      // Reset in the middle of a frame, then a clean restart
      resetDut();
      readyMode = 0;
      trig = 1'b1;
      waitBusy(1'b1, 400, "t6_start");
      trig = 1'b0;
      applyStimulus(6, 24'h000300, 0, 6);
      checkOutput("t6_pre_tvalid", 64'(tvalid), 64'd1);
      rst = 1'b1;
      #1;
      checkOutput("t6_tvalid", 64'(tvalid), 64'd0);
      checkOutput("t6_busy", 64'(busy), 64'd0);
      checkOutput("t6_frames", 64'(framesSent), 64'd0);
      checkOutput("t6_drop", 64'(dropCount), 64'd0);
      resetDut();
      startBeats = beatCount;
      trig = 1'b1;
      waitBusy(1'b1, 400, "t6_restart");
      trig = 1'b0;
      applyStimulus(32, 24'h000400, 0, 32);
      waitBusy(1'b0, 200, "t6_idle");
      waitDrained(50, "t6_queue");
      checkOutput("t6_beats", 64'(beatCount - startBeats), 64'd32);
      checkOutput("t6_frames_end", 64'(framesSent), 64'd2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
